// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU int/double conversion path.
package fpu_pkg;

    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        UNPACK   = 3'd1,
        CLASSIFY = 3'd2,
        SHIFT    = 3'd3,
        NEGATE   = 3'd4,
        PUT_Z    = 3'd5
    } state_t;

    localparam int unsigned DBL_BIAS    = 1023;
    localparam int unsigned DBL_EXP_MAX = 2047;
    localparam logic [31:0] INT32_MIN   = 32'h8000_0000;

endpackage

// File: rtl/doubletosint.sv
// binary64 -> int32 converter, truncating toward zero; aligns the mantissa
// with an iterative 1-bit-per-cycle right shift.
module doubletosint
    import fpu_pkg::*;
#(
    parameter logic [31:0] INVALID_VALUE = INT32_MIN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] input_a,
    output logic        complete,
    output logic [31:0] output_z
);

    state_t             state;
    logic [63:0]        a;
    logic               s;
    logic signed [11:0] e;
    logic [52:0]        m;
    logic [5:0]         cnt;
    logic [31:0]        z;
    logic               exp_all_ones;
    logic               exp_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= GET_A;
            a            <= '0;
            s            <= 1'b0;
            e            <= '0;
            m            <= '0;
            cnt          <= '0;
            z            <= '0;
            exp_all_ones <= 1'b0;
            exp_zero     <= 1'b0;
            output_z     <= '0;
            complete     <= 1'b0;
        end else if (!en) begin
            output_z <= '0;
            complete <= 1'b0;
            state    <= GET_A;
        end else begin
            case (state)
                GET_A: begin
                    a        <= input_a;
                    complete <= 1'b0;
                    state    <= UNPACK;
                end
                UNPACK: begin
                    s            <= a[63];
                    e            <= 12'({1'b0, a[62:52]}) - 12'(DBL_BIAS);
                    m            <= {1'b1, a[51:0]};
                    exp_all_ones <= (a[62:52] == 11'(DBL_EXP_MAX));
                    exp_zero     <= (a[62:52] == 11'd0);
                    state        <= CLASSIFY;
                end
                CLASSIFY: begin
                    // NaN/Inf and |x| >= 2^31 saturate to the invalid code
                    if (exp_all_ones || e >= 12'sd31) begin
                        z     <= INVALID_VALUE;
                        state <= PUT_Z;
                    end else if (exp_zero || e < 12'sd0) begin
                        z     <= '0;
                        state <= PUT_Z;
                    end else begin
                        cnt   <= 6'(12'sd52 - e);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 6'd0) begin
                        m   <= m >> 1;
                        cnt <= cnt - 6'd1;
                    end else begin
                        state <= NEGATE;
                    end
                end
                NEGATE: begin
                    z     <= s ? -m[31:0] : m[31:0];
                    state <= PUT_Z;
                end
                PUT_Z: begin
                    output_z <= z;
                    complete <= 1'b1;
                    state    <= GET_A;
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule
